// File: rtl/iob2axi_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : iob2axi_burst_ctrl
//  Description : Splits one DMA transfer (byte address, word count, direction)
//                into AXI4 bursts. Each burst stays inside a 4 KB page, is no
//                longer than MAX_BURST words and fits the data FIFO occupancy
//                or free space. A starved FIFO can release a partial burst
//                after TIMEOUT cycles. Abort and sticky error/done status are
//                supported.
//  Revision    : 1.0 - initial release
// ============================================================================
module iob2axi_burst_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int MAX_BURST = 256,
  parameter int TLEN_W    = 16,
  parameter int AVAIL_W   = 9,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  // transfer request / status
  input  logic              run,
  input  logic              direction,
  input  logic [ADDR_W-1:0] addr,
  input  logic [TLEN_W-1:0] length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  // FIFO words (write) or free slots (read)
  input  logic [AVAIL_W-1:0] avail,
  // burst engine handshake
  output logic              b_run,
  output logic              b_dir,
  output logic [ADDR_W-1:0] b_addr,
  output logic [LEN_W-1:0]  b_len,
  input  logic              b_ready,
  input  logic              b_done,
  input  logic              b_err
);

  // bytes-per-word shift and the number of word-offset bits inside a 4 KB page
  localparam int c_WB_LOG     = $clog2(DATA_W / 8);
  localparam int c_PAGE_W     = 12 - c_WB_LOG;
  localparam int c_PAGE_WORDS = 1 << c_PAGE_W;

  // common arithmetic width: wide enough for rem, MAX_BURST, to4k and avail
  // plus one guard bit so no comparison or subtraction wraps
  localparam int c_W1 = (TLEN_W > LEN_W + 1) ? TLEN_W : LEN_W + 1;
  localparam int c_W2 = (c_W1 > c_PAGE_W + 1) ? c_W1 : c_PAGE_W + 1;
  localparam int c_W3 = (c_W2 > AVAIL_W) ? c_W2 : AVAIL_W;
  localparam int c_CW = c_W3 + 1;

  // burst word count register holds 1..MAX_BURST
  localparam int c_NW = LEN_W + 1;

  localparam int                 c_TMR_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(TIMEOUT);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_WAIT  = 2'd1;
  localparam logic [1:0] c_S_ISSUE = 2'd2;
  localparam logic [1:0] c_S_BUSY  = 2'd3;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [TLEN_W-1:0]  r_rem;
  logic               r_dir;
  logic [c_NW-1:0]    r_n;
  logic [c_TMR_W-1:0] r_timer;
  logic               r_abort_pend;
  logic               r_done;
  logic               r_error;

  logic               w_misalign;
  logic [c_CW-1:0]    w_rem_c;
  logic [c_CW-1:0]    w_max_c;
  logic [c_CW-1:0]    w_to4k;
  logic [c_CW-1:0]    w_avail_c;
  logic [c_CW-1:0]    w_nfull;
  logic [c_CW-1:0]    w_rem_after;
  logic [c_NW-1:0]    w_n_m1;
  logic               w_go_full;
  logic               w_go_part;
  logic               w_abort_now;
  logic               w_last;
  logic               w_finish;

  // a start address is misaligned when any byte-in-word bit is set
  generate
    if (c_WB_LOG > 0) begin : g_align
      assign w_misalign = |addr[c_WB_LOG-1:0];
    end else begin : g_no_align
      assign w_misalign = 1'b0;
    end
  endgenerate

  // full burst size: min(rem, MAX_BURST, words left in the current 4 KB page)
  always_comb begin
    w_rem_c   = c_CW'(r_rem);
    w_max_c   = c_CW'(MAX_BURST);
    w_to4k    = c_CW'(c_PAGE_WORDS) - c_CW'(r_addr[11:c_WB_LOG]);
    w_avail_c = c_CW'(avail);
    w_nfull   = w_rem_c;
    if (w_max_c < w_nfull) w_nfull = w_max_c;
    if (w_to4k < w_nfull)  w_nfull = w_to4k;
  end

  // burst issue decisions and end-of-burst bookkeeping
  assign w_go_full   = (w_avail_c >= w_nfull);
  assign w_go_part   = (TIMEOUT != 0) && (r_timer == c_TMR_MAX) &&
                       (avail != '0) && !w_go_full;
  assign w_rem_after = c_CW'(r_rem) - c_CW'(r_n);
  // an abort arriving together with b_done counts as seen during the burst
  assign w_abort_now = r_abort_pend | abort;
  assign w_last      = (w_rem_after == '0) | w_abort_now | b_err;
  assign w_n_m1      = r_n - c_NW'(1);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // next-state logic; w_finish marks the cycle that ends a transfer
  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
    case (r_state)
      c_S_IDLE: begin
        if (run) begin
          if ((length == '0) || w_misalign) w_finish    = 1'b1;
          else                              w_state_nxt = c_S_WAIT;
        end
      end
      c_S_WAIT: begin
        if (abort) begin
          w_state_nxt = c_S_IDLE;
          w_finish    = 1'b1;
        end else if (w_go_full || w_go_part) begin
          w_state_nxt = c_S_ISSUE;
        end
      end
      c_S_ISSUE: begin
        if (b_ready) begin
          w_state_nxt = c_S_BUSY;
        end else if (abort) begin
          w_state_nxt = c_S_IDLE;
          w_finish    = 1'b1;
        end
      end
      c_S_BUSY: begin
        if (b_done) begin
          if (w_last) begin
            w_state_nxt = c_S_IDLE;
            w_finish    = 1'b1;
          end else begin
            w_state_nxt = c_S_WAIT;
          end
        end
      end
      default: w_state_nxt = c_S_IDLE;
    endcase
  end

  // burst request outputs: driven only while a burst is offered, zero otherwise
  always_comb begin
    busy   = (r_state != c_S_IDLE);
    b_run  = 1'b0;
    b_dir  = 1'b0;
    b_addr = '0;
    b_len  = '0;
    if (r_state == c_S_ISSUE) begin
      b_run  = 1'b1;
      b_dir  = r_dir;
      b_addr = r_addr;
      b_len  = w_n_m1[LEN_W-1:0];
    end
  end

  assign done  = r_done;
  assign error = r_error;

  // transfer bookkeeping: address, remaining words, burst size, timer, status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr       <= '0;
      r_rem        <= '0;
      r_dir        <= 1'b0;
      r_n          <= '0;
      r_timer      <= '0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_done <= w_finish;
      case (r_state)
        c_S_IDLE: begin
          if (run) begin
            r_addr       <= addr;
            r_rem        <= length;
            r_dir        <= direction;
            r_timer      <= '0;
            r_abort_pend <= 1'b0;
            // a zero-length request is a clean no-op, even if misaligned
            r_error      <= (length != '0) && w_misalign;
          end
        end
        c_S_WAIT: begin
          if (abort) r_error <= 1'b1;
          if (w_state_nxt == c_S_WAIT) begin
            // saturate so a late avail>0 still releases the partial burst
            if (r_timer != c_TMR_MAX) r_timer <= r_timer + c_TMR_W'(1);
          end else begin
            r_timer <= '0;
          end
          if (w_go_full)      r_n <= w_nfull[c_NW-1:0];
          else if (w_go_part) r_n <= w_avail_c[c_NW-1:0];
        end
        c_S_ISSUE: begin
          if (b_ready)    r_abort_pend <= abort;
          else if (abort) r_error      <= 1'b1;
        end
        c_S_BUSY: begin
          if (abort) r_abort_pend <= 1'b1;
          if (b_done) begin
            r_rem        <= r_rem - TLEN_W'(r_n);
            r_addr       <= r_addr + (ADDR_W'(r_n) << c_WB_LOG);
            r_error      <= r_error | b_err | w_abort_now;
            r_abort_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_iob2axi_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iob2axi_burst_ctrl
//  Description : Self-checking bench for iob2axi_burst_ctrl with a randomized
//                burst-engine responder and a plain-arithmetic burst planner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iob2axi_burst_ctrl;

  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        rst, run, direction, abort, b_ready, b_done, b_err;
  logic [31:0] addr;
  logic [15:0] length;
  logic [8:0]  avail;
  logic        busy, done, error, b_run, b_dir;
  logic [31:0] b_addr;
  logic [7:0]  b_len;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] got_a[$];
  int          got_l[$];
  logic        got_d[$];
  logic [31:0] exp_a[$];
  int          exp_l[$];

  int   n_done, done_cyc, first_run, run_stuck;
  logic busy_at_done, err_at_done;
  bit   timed_out;

  always #5 clk = ~clk;

  iob2axi_burst_ctrl #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(8), .MAX_BURST(256),
    .TLEN_W(16), .AVAIL_W(9), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .direction(direction), .addr(addr),
    .length(length), .abort(abort), .busy(busy), .done(done), .error(error),
    .avail(avail), .b_run(b_run), .b_dir(b_dir), .b_addr(b_addr), .b_len(b_len),
    .b_ready(b_ready), .b_done(b_done), .b_err(b_err)
  );

  // Reference planner: full bursts of min(rem, 256, words to next 4 KB page)
  task automatic model(input logic [31:0] a, input int len);
    logic [31:0] ca;
    int rem, to4k, n;
    exp_a.delete(); exp_l.delete();
    ca = a; rem = len;
    while (rem > 0) begin
      to4k = 1024 - int'((ca % 32'd4096) / 32'd4);
      n = rem;
      if (n > 256)  n = 256;
      if (n > to4k) n = to4k;
      exp_a.push_back(ca);
      exp_l.push_back(n - 1);
      ca  = ca + 32'(4 * n);
      rem = rem - n;
    end
  endtask

  // Runs one transfer, acting as the burst engine and recording what happens.
  // hook: 0 none, 1 abort during first burst, 2 spurious run during first
  // burst, 3 abort at cycle hook_cyc.
  task automatic do_xfer(input logic [31:0] a, input logic [15:0] len, input logic dir,
                         input int av, input int av2, input int err_idx,
                         input int hook, input int hook_cyc, input int max_cyc);
    int k, lat, eng, tail;
    bit prev_acc, hooked;
    got_a.delete(); got_l.delete(); got_d.delete();
    n_done = 0; done_cyc = -1; first_run = -1; run_stuck = 0;
    busy_at_done = 1'b0; err_at_done = 1'b0; timed_out = 1'b0;
    k = 0; lat = 0; eng = 0; tail = -1; prev_acc = 1'b0; hooked = 1'b0;
    @(negedge clk);
    avail = 9'(av); b_ready = 1'b1; b_done = 1'b0; b_err = 1'b0; abort = 1'b0;
    addr = a; length = len; direction = dir; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    forever begin
      if (prev_acc && b_run) run_stuck++;
      prev_acc = 1'b0;
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = k; busy_at_done = busy; err_at_done = error;
        end
        if (tail < 0) tail = 3;
      end
      if (b_run && first_run < 0) first_run = k;
      if (tail == 0) break;
      if (tail > 0) tail--;
      b_done = 1'b0; b_err = 1'b0; abort = 1'b0; run = 1'b0;
      if (hook == 3 && k == hook_cyc) abort = 1'b1;
      case (eng)
        0: begin
          if (b_run && b_ready) begin
            got_a.push_back(b_addr); got_l.push_back(int'(b_len)); got_d.push_back(b_dir);
            prev_acc = 1'b1; lat = $urandom_range(1, 4); eng = 1; avail = 9'(av2);
          end
        end
        1: begin
          b_ready = 1'b0;
          if (!hooked && hook == 1) begin abort = 1'b1; hooked = 1'b1; end
          if (!hooked && hook == 2) begin
            run = 1'b1; addr = $urandom; length = 16'($urandom_range(1, 100)); hooked = 1'b1;
          end
          lat--;
          if (lat == 0) begin
            b_done = 1'b1; b_err = ((got_a.size() - 1) == err_idx); eng = 2;
          end
        end
        default: begin b_ready = 1'b1; eng = 0; end
      endcase
      k++;
      if (k >= max_cyc) begin timed_out = 1'b1; break; end
      @(negedge clk);
    end
    b_ready = 1'b1; b_done = 1'b0; b_err = 1'b0; abort = 1'b0; run = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; direction = 1'b0; addr = '0; length = '0; abort = 1'b0;
    avail = '0; b_ready = 1'b1; b_done = 1'b0; b_err = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, error, b_run} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, error, b_run});
    end
    n_checks++;
    if ({b_dir, b_addr, b_len} !== 41'b0) begin
      n_fail++; $display("FAIL reset_bus: got addr=%h len=%0d dir=%b expected zeros", b_addr, b_len, b_dir);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_xfer(32'h0, 16'd16, 1'b1, 16, 16, -1, 0, 0, 100);
    model(32'h0, 16);
    n_checks++;
    if (timed_out || got_a.size() != exp_a.size()) begin
      n_fail++; $display("FAIL single_count: got %0d bursts (timeout=%0d) expected %0d", got_a.size(), timed_out, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a[i] || got_l[i] != exp_l[i] || got_d[i] !== 1'b1) begin
        n_fail++; $display("FAIL single_burst%0d: got %h/%0d/%b expected %h/%0d/1", i, got_a[i], got_l[i], got_d[i], exp_a[i], exp_l[i]);
      end
    end
    n_checks++;
    if (first_run != 1) begin
      n_fail++; $display("FAIL single_latency: got b_run at cycle %0d expected 1", first_run);
    end
    n_checks++;
    if (n_done != 1 || busy_at_done !== 1'b0 || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL single_done: got done=%0d busy=%b err=%b expected 1/0/0", n_done, busy_at_done, err_at_done);
    end
    n_checks++;
    if (run_stuck != 0) begin
      n_fail++; $display("FAIL single_brun_drop: got %0d stuck cycles expected 0", run_stuck);
    end
  endtask

  task automatic test_4k_split();
    do_xfer(32'hFF0, 16'd8, 1'b0, 8, 8, -1, 0, 0, 100);
    model(32'hFF0, 8);
    n_checks++;
    if (got_a.size() != exp_a.size() || exp_a.size() != 2) begin
      n_fail++; $display("FAIL 4k_count: got %0d bursts expected 2", got_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a[i] || got_l[i] != exp_l[i] || got_d[i] !== 1'b0) begin
        n_fail++; $display("FAIL 4k_burst%0d: got %h/%0d expected %h/%0d", i, got_a[i], got_l[i], exp_a[i], exp_l[i]);
      end
    end
    n_checks++;
    if (n_done != 1 || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL 4k_done: got done=%0d err=%b expected 1/0", n_done, err_at_done);
    end
  endtask

  task automatic test_long();
    do_xfer(32'h0, 16'd600, 1'b1, 511, 511, -1, 0, 0, 200);
    model(32'h0, 600);
    n_checks++;
    if (got_a.size() != 3) begin
      n_fail++; $display("FAIL long_count: got %0d bursts expected 3", got_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a[i] || got_l[i] != exp_l[i]) begin
        n_fail++; $display("FAIL long_burst%0d: got %h/%0d expected %h/%0d", i, got_a[i], got_l[i], exp_a[i], exp_l[i]);
      end
    end
    n_checks++;
    if (n_done != 1 || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL long_done: got done=%0d err=%b expected 1/0", n_done, err_at_done);
    end
  endtask

  task automatic test_timeout();
    do_xfer(32'h0, 16'd16, 1'b1, 5, 11, -1, 0, 0, 200);
    exp_a.delete(); exp_l.delete();
    exp_a.push_back(32'h0);  exp_l.push_back(4);
    exp_a.push_back(32'h14); exp_l.push_back(10);
    n_checks++;
    if (got_a.size() != 2) begin
      n_fail++; $display("FAIL timeout_count: got %0d bursts expected 2", got_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a[i] || got_l[i] != exp_l[i]) begin
        n_fail++; $display("FAIL timeout_burst%0d: got %h/%0d expected %h/%0d", i, got_a[i], got_l[i], exp_a[i], exp_l[i]);
      end
    end
    n_checks++;
    if (first_run < TO || first_run > TO + 2) begin
      n_fail++; $display("FAIL timeout_delay: got b_run at cycle %0d expected %0d..%0d", first_run, TO, TO + 2);
    end
    n_checks++;
    if (n_done != 1 || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL timeout_done: got done=%0d err=%b expected 1/0", n_done, err_at_done);
    end
  endtask

  task automatic test_zero_len();
    do_xfer(32'h100, 16'd0, 1'b0, 16, 16, -1, 0, 0, 50);
    n_checks++;
    if (got_a.size() != 0 || n_done != 1 || done_cyc != 0 || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL zero_len: got bursts=%0d done=%0d at %0d err=%b expected 0/1 at 0/0", got_a.size(), n_done, done_cyc, err_at_done);
    end
  endtask

  task automatic test_misalign();
    do_xfer(32'h2, 16'd16, 1'b0, 16, 16, -1, 0, 0, 50);
    n_checks++;
    if (got_a.size() != 0 || n_done != 1 || done_cyc != 0 || err_at_done !== 1'b1) begin
      n_fail++; $display("FAIL misalign: got bursts=%0d done=%0d at %0d err=%b expected 0/1 at 0/1", got_a.size(), n_done, done_cyc, err_at_done);
    end
  endtask

  task automatic test_abort();
    do_xfer(32'h0, 16'd768, 1'b1, 511, 511, -1, 1, 0, 200);
    n_checks++;
    if (got_a.size() != 1 || n_done != 1 || err_at_done !== 1'b1 || busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy: got bursts=%0d done=%0d err=%b busy=%b expected 1/1/1/0", got_a.size(), n_done, err_at_done, busy_at_done);
    end
    do_xfer(32'h0, 16'd16, 1'b1, 0, 0, -1, 3, 5, 100);
    n_checks++;
    if (got_a.size() != 0 || n_done != 1 || done_cyc != 6 || err_at_done !== 1'b1) begin
      n_fail++; $display("FAIL abort_wait: got bursts=%0d done=%0d at %0d err=%b expected 0/1 at 6/1", got_a.size(), n_done, done_cyc, err_at_done);
    end
  endtask

  task automatic test_berr();
    do_xfer(32'h0, 16'd768, 1'b0, 511, 511, 0, 0, 0, 200);
    n_checks++;
    if (got_a.size() != 1 || n_done != 1 || err_at_done !== 1'b1) begin
      n_fail++; $display("FAIL berr: got bursts=%0d done=%0d err=%b expected 1/1/1", got_a.size(), n_done, err_at_done);
    end
    n_checks++;
    if (error !== 1'b1) begin
      n_fail++; $display("FAIL berr_sticky: got error=%b expected 1", error);
    end
  endtask

  task automatic test_run_ignored();
    do_xfer(32'h3F00, 16'd300, 1'b1, 511, 511, -1, 2, 0, 200);
    model(32'h3F00, 300);
    n_checks++;
    if (got_a.size() != exp_a.size()) begin
      n_fail++; $display("FAIL runign_count: got %0d bursts expected %0d", got_a.size(), exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_checks++;
      if (got_a[i] !== exp_a[i] || got_l[i] != exp_l[i]) begin
        n_fail++; $display("FAIL runign_burst%0d: got %h/%0d expected %h/%0d", i, got_a[i], got_l[i], exp_a[i], exp_l[i]);
      end
    end
    n_checks++;
    if (n_done != 1 || err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL runign_done: got done=%0d err=%b expected 1/0", n_done, err_at_done);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int len;
    logic d;
    for (int t = 0; t < 8; t++) begin
      a   = $urandom & 32'hFFFF_FFFC;
      len = $urandom_range(1, 900);
      d   = 1'($urandom_range(0, 1));
      do_xfer(a, 16'(len), d, 511, 511, -1, 0, 0, 400);
      model(a, len);
      n_checks++;
      if (timed_out || got_a.size() != exp_a.size()) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d bursts expected %0d (a=%h len=%0d)", t, got_a.size(), exp_a.size(), a, len);
      end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
        n_checks++;
        if (got_a[i] !== exp_a[i] || got_l[i] != exp_l[i] || got_d[i] !== d) begin
          n_fail++; $display("FAIL rand%0d_burst%0d: got %h/%0d/%b expected %h/%0d/%b", t, i, got_a[i], got_l[i], got_d[i], exp_a[i], exp_l[i], d);
        end
      end
      n_checks++;
      if (n_done != 1 || err_at_done !== 1'b0 || run_stuck != 0) begin
        n_fail++; $display("FAIL rand%0d_done: got done=%0d err=%b stuck=%0d expected 1/0/0", t, n_done, err_at_done, run_stuck);
      end
    end
  endtask

  task automatic test_reset_mid();
    int  k;
    bit  seen;
    @(negedge clk);
    avail = 9'd16; b_ready = 1'b1; addr = 32'h0; length = 16'd16; direction = 1'b1; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    k = 0;
    while (!b_run && k < 10) begin @(negedge clk); k++; end
    n_checks++;
    if (b_run !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_issue: got b_run=%b expected 1", b_run);
    end
    @(negedge clk);
    b_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || b_run !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_busy: got busy=%b b_run=%b expected 1/0", busy, b_run);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, error, b_run, b_dir, b_addr, b_len} !== 45'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got busy=%b done=%b b_run=%b addr=%h expected all 0", busy, done, b_run, b_addr);
    end
    @(negedge clk);
    rst = 1'b0; b_ready = 1'b1; b_done = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      b_done = 1'b0;
      if (done || busy || b_run) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL rstmid_quiet: got activity after reset expected none");
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_4k_split();
    test_long();
    test_timeout();
    test_zero_len();
    test_misalign();
    test_abort();
    test_berr();
    test_run_ignored();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iob2axi_burst_ctrl.md
Name: iob2axi_burst_ctrl

Overview:
Parametrised burst planner for the AXI DMA path. It takes one whole transfer (byte address, total word count, direction) and splits it into AXI4 bursts. Each burst respects the 4 KB boundary, the maximum burst length MAX_BURST and the buffer occupancy or space reported by the data FIFO. It drives the existing read/write burst engines through a run/ready/done handshake and adds features the single-shot controller lacks: total-length transfers, a timeout-driven partial burst, abort, and sticky error/done status.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width in bits; DATA_W/8 is a power of 2
LEN_W, 8, AXI len field width
MAX_BURST, 256, max words per burst, 1..2^LEN_W
TLEN_W, 16, total transfer length width (words)
AVAIL_W, 9, width of FIFO availability input
TIMEOUT, 255, cycles of starvation before a partial burst is issued; 0 disables partial bursts

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
run  in  1  start pulse; ignored unless idle
direction  in  1  0 = read (AXI to FIFO), 1 = write (FIFO to AXI)
addr  in  ADDR_W  start byte address, must be word-aligned
length  in  TLEN_W  total words
abort  in  1  stop after current burst
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer end
error  out  1  sticky until next accepted run
avail  in  AVAIL_W  words in FIFO (write) or free slots (read)
b_run  out  1  burst request, held until accepted
b_dir  out  1  burst direction
b_addr  out  ADDR_W  burst start byte address
b_len  out  LEN_W  burst words minus 1
b_ready  in  1  engine idle; b_run&b_ready = accepted
b_done  in  1  one-cycle pulse, burst complete
b_err  in  1  qualified by b_done; engine saw a non-OKAY response

Behaviour:
- Reset: all outputs 0; state IDLE; remaining count, address and timer cleared. Reset asserted mid-transfer abandons the transfer immediately, with no done pulse.
- Word address: waddr = addr >> log2(DATA_W/8).
- Words to the 4 KB boundary: to4k = 2^(12-log2(DATA_W/8)) - waddr[low bits].
- Full burst size: n_full = min(rem, MAX_BURST, to4k). All arithmetic is widened so that no intermediate term wraps.
- IDLE: run with length==0 -> done pulse next cycle, no burst issued, error stays 0. run with a misaligned addr -> error=1 and done pulse next cycle. Otherwise latch addr/length/direction, set rem=length, clear error, busy=1, go to WAIT.
- WAIT: timer increments each cycle.
  - avail >= n_full -> n = n_full, go to ISSUE.
  - Else, if TIMEOUT != 0, timer == TIMEOUT and avail > 0 -> n = avail, go to ISSUE.
  - Timer clears when leaving WAIT.
  - abort in WAIT -> IDLE, done pulse, error=1.
- ISSUE: b_run=1, b_addr = current addr, b_len = n-1, b_dir = direction. These values are stable while b_run is high. On b_run&b_ready: b_run=0 next cycle, go to BUSY. abort in ISSUE before acceptance behaves as abort in WAIT.
- BUSY: on b_done:
  - rem -= n; addr += n*DATA_W/8; error |= b_err.
  - If rem==0, or abort was registered during the burst, or b_err -> IDLE, done pulse, busy=0 the same cycle as done.
  - Otherwise go back to WAIT.
- abort arriving in BUSY is registered and acted on at b_done. abort in IDLE is ignored.
- run while busy is ignored.
- Simultaneous b_done and abort are treated as abort seen during the burst.
- Burst issue latency: one cycle from entering WAIT with enough avail to b_run.

Test Plan:
- DATA_W=32, addr=0x0, length=16, avail=16 -> one burst b_addr=0x0, b_len=15; after b_done, done pulses and error=0.
- addr=0xFF0, length=8, avail=8 -> two bursts, (0xFF0, b_len=3) then (0x1000, b_len=3); no burst crosses 4 KB.
- addr=0x0, length=600, avail=511 -> bursts (0x000, 255), (0x400, 255), (0x800, 87); done after the third b_done.
- length=16, avail held at 5, TIMEOUT=10 -> b_run after 10 starved cycles with b_len=4; rem becomes 11; a later avail=11 yields b_len=10; then done.
- abort asserted during the first of three bursts -> no second b_run; done at the first b_done; error=1. Separately, b_err=1 on the first b_done -> stop, error=1.
- length=0 -> done, no b_run. addr=0x2 -> error=1 and done. rst mid-BUSY -> all outputs 0 and no done.
